rx_frame_analyser: RTL and testbench

//  Parametrised successor of the RxCore byte analyser. Sits between the Rx shift register/FSM and the Rx FIFO.

---
 rtl/rx_frame_analyser.sv | 199 +++++++++++++++++++
 tb/tb_rx_frame_analyser.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_analyser.sv
// Rx frame analyser: extracts 5..DATA_W data bits per frame, judges parity and stop bit,
// writes one word per frame to the Rx FIFO and keeps sticky error flags and saturating counters.
`timescale 1ns/1ps
module rx_frame_analyser #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned FRAME_W   = 12,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned SAMPLE_PT = 7,
   parameter int unsigned ERRCNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FRAME_W-1:0]  frame_i,
   input  logic [4:0]          State_i,
   input  logic [CNT_W-1:0]    BitWidthCnt_i,
   input  logic [3:0]          data_len_i,
   input  logic [2:0]          parity_mode_i,
   input  logic                msb_first_i,
   input  logic                drop_err_i,
   input  logic                err_clr_i,
   output logic                n_we_o,
   output logic [DATA_W-1:0]   data_o,
   input  logic                p_full_i,
   output logic                p_ParityError_o,
   output logic                p_FrameError_o,
   output logic                p_OverrunError_o,
   output logic [ERRCNT_W-1:0] parity_cnt_o,
   output logic [ERRCNT_W-1:0] frame_cnt_o,
   output logic [ERRCNT_W-1:0] overrun_cnt_o
);

   localparam logic [4:0] RxIdle   = 5'b00001;
   localparam logic [4:0] RxData   = 5'b00100;
   localparam logic [4:0] RxParity = 5'b01000;
   localparam logic [4:0] RxStop   = 5'b10000;

   localparam logic [CNT_W-1:0]    JudgeCnt = CNT_W'(SAMPLE_PT + 1);
   localparam logic [ERRCNT_W-1:0] CntMax   = '1;

   typedef enum logic [4:0] {
      AIdle   = 5'b00001,
      AData   = 5'b00010,
      AParity = 5'b00100,
      AStop   = 5'b01000,
      AWrite  = 5'b10000
   } a_state_e;

   a_state_e            state_q;
   logic [DATA_W-1:0]   data_q;
   logic [2:0]          mode_q;
   logic                drop_q;
   logic                perr_q;
   logic                ferr_q;

   logic                par_flag_q, frm_flag_q, ovr_flag_q;
   logic [ERRCNT_W-1:0] par_cnt_q, frm_cnt_q, ovr_cnt_q;

   logic [3:0]          len;
   logic [DATA_W-1:0]   rev;
   logic [DATA_W-1:0]   mask;
   logic [DATA_W-1:0]   capt;
   logic                judge;
   logic                perr_now;
   logic                par_evt, frm_evt, ovr_evt;
   logic                we;

   logic unused_frame;
   assign unused_frame = ^frame_i[FRAME_W-1:DATA_W];

   always_comb begin
      if (data_len_i >= 4'd5 && {28'd0, data_len_i} <= DATA_W) begin
         len = data_len_i;
      end else begin
         len = 4'(DATA_W);
      end
   end

   // LSB-first frames arrive oldest-bit-highest, so reverse then right-align to len.
   always_comb begin
      rev = '0;
      for (int k = 0; k < int'(DATA_W); k++) begin
         rev[k] = frame_i[DATA_W-1-k];
      end
      mask = ~({DATA_W{1'b1}} << len);
      if (msb_first_i) begin
         capt = frame_i[DATA_W-1:0] & mask;
      end else begin
         capt = (rev >> (4'(DATA_W) - len)) & mask;
      end
   end

   assign judge = (BitWidthCnt_i == JudgeCnt);

   always_comb begin
      case (mode_q)
         3'b001:  perr_now = (^data_q) != frame_i[0];
         3'b010:  perr_now = (^data_q) == frame_i[0];
         3'b011:  perr_now = (frame_i[0] != 1'b1);
         3'b100:  perr_now = (frame_i[0] != 1'b0);
         default: perr_now = 1'b0;
      endcase
   end

   assign par_evt = (state_q == AParity) && (State_i == RxParity) && judge && perr_now;
   assign frm_evt = (state_q == AStop) && (State_i == RxStop) && judge && !frame_i[0];
   assign ovr_evt = (state_q == AWrite) && p_full_i;
   assign we      = (state_q == AWrite) && !p_full_i && !(drop_q && (perr_q || ferr_q));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= AIdle;
         data_q  <= '0;
         mode_q  <= 3'b000;
         drop_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         unique case (state_q)
            AIdle: begin
               perr_q <= 1'b0;
               ferr_q <= 1'b0;
               if (State_i == RxData) state_q <= AData;
            end
            AData: begin
               if (State_i == RxIdle) begin
                  state_q <= AIdle;
               end else if (State_i != RxData) begin
                  data_q <= capt;
                  mode_q <= parity_mode_i;
                  drop_q <= drop_err_i;
                  if (State_i == RxParity)    state_q <= AParity;
                  else if (State_i == RxStop) state_q <= AStop;
                  else                        state_q <= AIdle;
               end
            end
            AParity: begin
               if (State_i == RxIdle) begin
                  state_q <= AIdle;
               end else if (State_i == RxParity && judge) begin
                  perr_q  <= perr_now;
                  state_q <= AStop;
               end
            end
            AStop: begin
               if (State_i == RxIdle) begin
                  state_q <= AIdle;
               end else if (State_i == RxStop && judge) begin
                  ferr_q  <= ~frame_i[0];
                  state_q <= AWrite;
               end
            end
            AWrite: state_q <= AIdle;
            default: state_q <= AIdle;
         endcase
      end
   end

   // A clear in the same cycle as an error event wins; the event is lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_flag_q <= 1'b0;
         frm_flag_q <= 1'b0;
         ovr_flag_q <= 1'b0;
         par_cnt_q  <= '0;
         frm_cnt_q  <= '0;
         ovr_cnt_q  <= '0;
      end else if (err_clr_i) begin
         par_flag_q <= 1'b0;
         frm_flag_q <= 1'b0;
         ovr_flag_q <= 1'b0;
         par_cnt_q  <= '0;
         frm_cnt_q  <= '0;
         ovr_cnt_q  <= '0;
      end else begin
         if (par_evt) begin
            par_flag_q <= 1'b1;
            if (par_cnt_q != CntMax) par_cnt_q <= par_cnt_q + ERRCNT_W'(1);
         end
         if (frm_evt) begin
            frm_flag_q <= 1'b1;
            if (frm_cnt_q != CntMax) frm_cnt_q <= frm_cnt_q + ERRCNT_W'(1);
         end
         if (ovr_evt) begin
            ovr_flag_q <= 1'b1;
            if (ovr_cnt_q != CntMax) ovr_cnt_q <= ovr_cnt_q + ERRCNT_W'(1);
         end
      end
   end

   assign n_we_o           = ~we;
   assign data_o           = data_q;
   assign p_ParityError_o  = par_flag_q;
   assign p_FrameError_o   = frm_flag_q;
   assign p_OverrunError_o = ovr_flag_q;
   assign parity_cnt_o     = par_cnt_q;
   assign frame_cnt_o      = frm_cnt_q;
   assign overrun_cnt_o    = ovr_cnt_q;

endmodule

// File: tb/tb_rx_frame_analyser.sv
// Bench for rx_frame_analyser: emulates the Rx FSM/shift register bit by bit and checks
// writes, data, latency, flags and counters against a frame-level reference model.
`timescale 1ns/1ps
module tb_rx_frame_analyser;

   localparam int DATA_W    = 8;
   localparam int FRAME_W   = 12;
   localparam int CNT_W     = 4;
   localparam int SAMPLE_PT = 7;
   localparam int ERRCNT_W  = 8;
   localparam int BIT_T     = 10;

   localparam logic [4:0] S_IDLE   = 5'b00001;
   localparam logic [4:0] S_START  = 5'b00010;
   localparam logic [4:0] S_DATA   = 5'b00100;
   localparam logic [4:0] S_PARITY = 5'b01000;
   localparam logic [4:0] S_STOP   = 5'b10000;

   logic                clk;
   logic                rst;
   logic [FRAME_W-1:0]  frame_i;
   logic [4:0]          State_i;
   logic [CNT_W-1:0]    BitWidthCnt_i;
   logic [3:0]          data_len_i;
   logic [2:0]          parity_mode_i;
   logic                msb_first_i;
   logic                drop_err_i;
   logic                err_clr_i;
   logic                n_we_o;
   logic [DATA_W-1:0]   data_o;
   logic                p_full_i;
   logic                p_ParityError_o;
   logic                p_FrameError_o;
   logic                p_OverrunError_o;
   logic [ERRCNT_W-1:0] parity_cnt_o;
   logic [ERRCNT_W-1:0] frame_cnt_o;
   logic [ERRCNT_W-1:0] overrun_cnt_o;

   rx_frame_analyser #(
      .DATA_W   (DATA_W),
      .FRAME_W  (FRAME_W),
      .CNT_W    (CNT_W),
      .SAMPLE_PT(SAMPLE_PT),
      .ERRCNT_W (ERRCNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .frame_i         (frame_i),
      .State_i         (State_i),
      .BitWidthCnt_i   (BitWidthCnt_i),
      .data_len_i      (data_len_i),
      .parity_mode_i   (parity_mode_i),
      .msb_first_i     (msb_first_i),
      .drop_err_i      (drop_err_i),
      .err_clr_i       (err_clr_i),
      .n_we_o          (n_we_o),
      .data_o          (data_o),
      .p_full_i        (p_full_i),
      .p_ParityError_o (p_ParityError_o),
      .p_FrameError_o  (p_FrameError_o),
      .p_OverrunError_o(p_OverrunError_o),
      .parity_cnt_o    (parity_cnt_o),
      .frame_cnt_o     (frame_cnt_o),
      .overrun_cnt_o   (overrun_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] wr_data_q[$];
   int         wr_cyc_q[$];
   always @(negedge clk) begin
      if (rst === 1'b1 && n_we_o === 1'b0) begin
         wr_data_q.push_back(data_o);
         wr_cyc_q.push_back(cyc);
      end
   end

   int errors = 0;
   int checks = 0;
   int judge_cyc = 0;

   // Reference model state
   bit         m_pf, m_ff, m_of;
   int         m_pc, m_fc, m_oc;
   logic [7:0] m_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_flags();
      check("parity flag", 32'(p_ParityError_o), 32'(m_pf));
      check("frame flag", 32'(p_FrameError_o), 32'(m_ff));
      check("overrun flag", 32'(p_OverrunError_o), 32'(m_of));
      check("parity cnt", 32'(parity_cnt_o), m_pc);
      check("frame cnt", 32'(frame_cnt_o), m_fc);
      check("overrun cnt", 32'(overrun_cnt_o), m_oc);
   endtask

   task automatic tick(input logic [4:0] st, input int c, input bit sh, input bit b);
      @(posedge clk);
      #1;
      State_i       = st;
      BitWidthCnt_i = CNT_W'(c);
      if (sh) frame_i = {frame_i[FRAME_W-2:0], b};
   endtask

   task automatic send_bit(input logic [4:0] st, input bit b, input bit is_stop);
      for (int c = 0; c < BIT_T; c++) begin
         tick(st, c, (c == SAMPLE_PT), b);
         if (is_stop && c == SAMPLE_PT + 1) judge_cyc = cyc;
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v < 255) ? v + 1 : 255;
   endfunction

   task automatic setup(input int len_cfg, input bit msb, input bit [2:0] mode,
                        input bit full, input bit drop);
      @(posedge clk);
      #1;
      State_i       = S_IDLE;
      BitWidthCnt_i = '0;
      data_len_i    = 4'(len_cfg);
      parity_mode_i = mode;
      msb_first_i   = msb;
      drop_err_i    = drop;
      p_full_i      = full;
      wr_data_q.delete();
      wr_cyc_q.delete();
   endtask

   task automatic run_frame(input logic [7:0] d_in, input int len_cfg, input bit msb,
                            input bit [2:0] mode, input bit par_ok, input bit stop,
                            input bit full, input bit drop, input bit use_exp,
                            input bit exp_wr, input logic [7:0] exp_data);
      int         eff;
      bit         has_par;
      bit         p, perr, ferr, wr;
      int         ones;
      logic [7:0] d;
      logic [7:0] e_data;
      bit         e_wr;
      eff     = (len_cfg >= 5 && len_cfg <= DATA_W) ? len_cfg : DATA_W;
      d       = d_in & 8'((1 << eff) - 1);
      has_par = (mode >= 3'd1 && mode <= 3'd4);
      ones    = $countones(d);
      case (mode)
         3'd1:    p = (ones % 2) == 1;
         3'd2:    p = (ones % 2) == 0;
         3'd3:    p = 1'b1;
         default: p = 1'b0;
      endcase
      if (!par_ok) p = ~p;

      setup(len_cfg, msb, mode, full, drop);
      tick(S_IDLE, 0, 0, 0);
      send_bit(S_START, 1'b0, 0);
      for (int i = 0; i < eff; i++) begin
         send_bit(S_DATA, msb ? d[eff-1-i] : d[i], 0);
      end
      if (has_par) send_bit(S_PARITY, p, 0);
      send_bit(S_STOP, stop, 1);
      tick(S_IDLE, 0, 0, 0);
      tick(S_IDLE, 0, 0, 0);

      case (mode)
         3'd1:    perr = ((ones + int'(p)) % 2) != 0;
         3'd2:    perr = ((ones + int'(p)) % 2) == 0;
         3'd3:    perr = (p != 1'b1);
         3'd4:    perr = (p != 1'b0);
         default: perr = 1'b0;
      endcase
      ferr = !stop;
      wr   = !full && !(drop && (perr || ferr));
      if (perr) begin m_pf = 1; m_pc = sat_inc(m_pc); end
      if (ferr) begin m_ff = 1; m_fc = sat_inc(m_fc); end
      if (full) begin m_of = 1; m_oc = sat_inc(m_oc); end
      m_data = d;

      e_wr   = use_exp ? exp_wr : wr;
      e_data = use_exp ? exp_data : d;
      check("write count", wr_data_q.size(), 32'(e_wr));
      if (e_wr && wr_data_q.size() == 1) begin
         check("write data", 32'(wr_data_q[0]), 32'(e_data));
         check("write latency", wr_cyc_q[0], judge_cyc + 1);
      end
      check("data_o after frame", 32'(data_o), 32'(e_data));
      check_flags();
   endtask

   task automatic clear_errs();
      @(posedge clk);
      #1;
      err_clr_i = 1'b1;
      State_i   = S_IDLE;
      @(posedge clk);
      #1;
      err_clr_i = 1'b0;
      m_pf = 0; m_ff = 0; m_of = 0;
      m_pc = 0; m_fc = 0; m_oc = 0;
   endtask

   typedef struct {
      logic [7:0] d;
      int         len;
      bit         msb;
      bit [2:0]   mode;
      bit         par_ok;
      bit         stop;
      bit         full;
      bit         drop;
      bit         exp_wr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{8'h5A, 8,  0, 3'd1, 1, 1, 0, 0, 1, 8'h5A};
      vecs[1]  = '{8'h35, 7,  1, 3'd2, 0, 1, 0, 1, 0, 8'h35};
      vecs[2]  = '{8'h35, 7,  1, 3'd2, 0, 1, 0, 0, 1, 8'h35};
      vecs[3]  = '{8'hC3, 8,  0, 3'd0, 1, 0, 0, 1, 0, 8'hC3};
      vecs[4]  = '{8'hC3, 8,  0, 3'd0, 1, 0, 0, 0, 1, 8'hC3};
      vecs[5]  = '{8'h15, 5,  0, 3'd3, 1, 1, 0, 0, 1, 8'h15};
      vecs[6]  = '{8'h0A, 6,  1, 3'd4, 1, 1, 0, 0, 1, 8'h0A};
      vecs[7]  = '{8'hFF, 15, 0, 3'd1, 1, 1, 0, 0, 1, 8'hFF};
      vecs[8]  = '{8'h1F, 5,  1, 3'd1, 0, 1, 0, 0, 1, 8'h1F};
      vecs[9]  = '{8'h3C, 8,  0, 3'd7, 1, 1, 0, 1, 1, 8'h3C};
      vecs[10] = '{8'h81, 4,  1, 3'd2, 1, 1, 1, 0, 0, 8'h81};

      rst = 1'b0;
      frame_i = '1;
      State_i = S_IDLE;
      BitWidthCnt_i = '0;
      data_len_i = 4'd8;
      parity_mode_i = 3'd0;
      msb_first_i = 1'b0;
      drop_err_i = 1'b0;
      err_clr_i = 1'b0;
      p_full_i = 1'b0;
      m_pf = 0; m_ff = 0; m_of = 0;
      m_pc = 0; m_fc = 0; m_oc = 0;
      m_data = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset n_we_o", 32'(n_we_o), 32'd1);
      check("reset data_o", 32'(data_o), 32'd0);
      check_flags();
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         run_frame(vecs[i].d, vecs[i].len, vecs[i].msb, vecs[i].mode, vecs[i].par_ok,
                   vecs[i].stop, vecs[i].full, vecs[i].drop, 1, vecs[i].exp_wr,
                   vecs[i].exp_data);
      end

      // Three frames into a full FIFO, then clear
      clear_errs();
      for (int i = 0; i < 3; i++) begin
         run_frame(8'h40 + 8'(i), 8, 0, 3'd1, 1, 1, 1, 0, 1, 0, 8'h40 + 8'(i));
      end
      check("overrun cnt after 3", 32'(overrun_cnt_o), 32'd3);
      check("overrun flag after 3", 32'(p_OverrunError_o), 32'd1);
      clear_errs();
      @(negedge clk);
      check("overrun cnt cleared", 32'(overrun_cnt_o), 32'd0);
      check("overrun flag cleared", 32'(p_OverrunError_o), 32'd0);

      // Rx FSM abort mid-data, after leaving one error flag set
      run_frame(8'h12, 8, 0, 3'd0, 1, 0, 0, 0, 0, 0, 8'h00);
      setup(8, 0, 3'd1, 0, 0);
      tick(S_IDLE, 0, 0, 0);
      send_bit(S_START, 1'b0, 0);
      for (int i = 0; i < 3; i++) send_bit(S_DATA, 1'b1, 0);
      repeat (3) tick(S_IDLE, 0, 0, 0);
      @(negedge clk);
      check("abort no write", wr_data_q.size(), 32'd0);
      check("abort data_o held", 32'(data_o), 32'(m_data));
      check_flags();
      run_frame(8'hA5, 8, 1, 3'd1, 1, 1, 0, 0, 1, 1, 8'hA5);

      // Parity counter saturation
      clear_errs();
      for (int i = 0; i < 300; i++) begin
         run_frame(8'h15, 5, 0, 3'd3, 0, 1, 0, 1, 0, 0, 8'h00);
      end
      check("parity cnt saturated", 32'(parity_cnt_o), 32'd255);
      run_frame(8'h15, 5, 0, 3'd3, 1, 1, 0, 0, 1, 1, 8'h15);

      // Randomized frames against the model
      clear_errs();
      for (int i = 0; i < 60; i++) begin
         run_frame(8'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                   1'($urandom_range(0, 1)), 0, 0, 8'h00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
